instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 257 +++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// instr_encoder: turns (cmd, addressing mode, operand) into a 6502 opcode byte plus 0-2 little-endian operand bytes.
// Optional build macro INSTR_ENC_ILLEGAL_NOP_EN: illegal pairs are emitted as NOP (EA) instead of being dropped, err still pulses.
module instr_encoder #(
  parameter int CMD_W  = 6,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              err,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [CMD_W-1:0]
    CMD_BRK = 0,  CMD_ORA = 1,  CMD_ASL = 2,  CMD_PHP = 3,  CMD_BPL = 4,  CMD_CLC = 5,
    CMD_JSR = 6,  CMD_AND = 7,  CMD_BIT = 8,  CMD_ROL = 9,  CMD_PLP = 10, CMD_BMI = 11,
    CMD_SEC = 12, CMD_RTI = 13, CMD_EOR = 14, CMD_LSR = 15, CMD_PHA = 16, CMD_JMP = 17,
    CMD_BVC = 18, CMD_CLI = 19, CMD_RTS = 20, CMD_ADC = 21, CMD_ROR = 22, CMD_PLA = 23,
    CMD_BVS = 24, CMD_SEI = 25, CMD_STA = 26, CMD_STY = 27, CMD_STX = 28, CMD_DEY = 29,
    CMD_TXA = 30, CMD_BCC = 31, CMD_TYA = 32, CMD_TXS = 33, CMD_LDY = 34, CMD_LDA = 35,
    CMD_LDX = 36, CMD_TAY = 37, CMD_TAX = 38, CMD_BCS = 39, CMD_CLV = 40, CMD_TSX = 41,
    CMD_CPY = 42, CMD_CMP = 43, CMD_DEC = 44, CMD_INY = 45, CMD_DEX = 46, CMD_BNE = 47,
    CMD_CLD = 48, CMD_CPX = 49, CMD_SBC = 50, CMD_INX = 51, CMD_NOP = 52, CMD_BEQ = 53,
    CMD_SED = 54, CMD_INC = 55, CMD_ASLA = 56, CMD_ROLA = 57, CMD_LSRA = 58, CMD_RORA = 59;

  localparam logic [ADDR_W-1:0]
    AM_IMP = 0, AM_ACC = 1, AM_IMM = 2, AM_ZPG = 3, AM_ZPGX = 4, AM_ZPGY = 5, AM_ABS = 6,
    AM_ABSX = 7, AM_ABSY = 8, AM_IND = 9, AM_XIND = 10, AM_INDY = 11, AM_REL = 12;

  typedef enum logic [1:0] {IDLE, EMIT_OP, EMIT_LO, EMIT_HI} state_t;
  state_t state;

  logic       lk_legal;
  logic [7:0] lk_op;
  logic [1:0] lk_len;
  logic [7:0] base;
  logic [7:0] lo;
  logic       imp_only;
  logic       acc_form;
  logic       rel_only;

  always_comb begin
    lk_legal = 1'b1;
    lk_op    = 8'h00;
    base     = 8'h00;
    lo       = 8'h00;
    imp_only = 1'b0;
    acc_form = 1'b0;
    rel_only = 1'b0;
    case (address)
      AM_IMM, AM_ZPG, AM_ZPGX, AM_ZPGY, AM_XIND, AM_INDY, AM_REL: lk_len = 2'd1;
      AM_ABS, AM_ABSX, AM_ABSY, AM_IND:                           lk_len = 2'd2;
      default:                                                    lk_len = 2'd0;
    endcase
    case (cmd)
      // ALU group: the mode selects the low bits, the instruction selects the top three bits.
      CMD_ORA, CMD_AND, CMD_EOR, CMD_ADC, CMD_STA, CMD_LDA, CMD_CMP, CMD_SBC: begin
        case (cmd)
          CMD_AND: base = 8'h20;
          CMD_EOR: base = 8'h40;
          CMD_ADC: base = 8'h60;
          CMD_STA: base = 8'h80;
          CMD_LDA: base = 8'hA0;
          CMD_CMP: base = 8'hC0;
          CMD_SBC: base = 8'hE0;
          default: base = 8'h00;
        endcase
        case (address)
          AM_XIND: lo = 8'h01;
          AM_ZPG:  lo = 8'h05;
          AM_IMM:  lo = 8'h09;
          AM_ABS:  lo = 8'h0D;
          AM_INDY: lo = 8'h11;
          AM_ZPGX: lo = 8'h15;
          AM_ABSY: lo = 8'h19;
          AM_ABSX: lo = 8'h1D;
          default: lk_legal = 1'b0;
        endcase
        lk_op = base | lo;
        if (cmd == CMD_STA && address == AM_IMM) lk_legal = 1'b0;
      end
      CMD_ASL, CMD_ROL, CMD_LSR, CMD_ROR, CMD_DEC, CMD_INC: begin
        case (cmd)
          CMD_ROL: base = 8'h20;
          CMD_LSR: base = 8'h40;
          CMD_ROR: base = 8'h60;
          CMD_DEC: base = 8'hC0;
          CMD_INC: base = 8'hE0;
          default: base = 8'h00;
        endcase
        case (address)
          AM_ZPG:  lo = 8'h06;
          AM_ABS:  lo = 8'h0E;
          AM_ZPGX: lo = 8'h16;
          AM_ABSX: lo = 8'h1E;
          default: lk_legal = 1'b0;
        endcase
        lk_op = base | lo;
      end
      CMD_STX: case (address)
        AM_ZPG: lk_op = 8'h86;  AM_ABS: lk_op = 8'h8E;  AM_ZPGY: lk_op = 8'h96;
        default: lk_legal = 1'b0;
      endcase
      CMD_LDX: case (address)
        AM_IMM: lk_op = 8'hA2;  AM_ZPG: lk_op = 8'hA6;  AM_ABS: lk_op = 8'hAE;
        AM_ZPGY: lk_op = 8'hB6; AM_ABSY: lk_op = 8'hBE;
        default: lk_legal = 1'b0;
      endcase
      CMD_STY: case (address)
        AM_ZPG: lk_op = 8'h84;  AM_ABS: lk_op = 8'h8C;  AM_ZPGX: lk_op = 8'h94;
        default: lk_legal = 1'b0;
      endcase
      CMD_LDY: case (address)
        AM_IMM: lk_op = 8'hA0;  AM_ZPG: lk_op = 8'hA4;  AM_ABS: lk_op = 8'hAC;
        AM_ZPGX: lk_op = 8'hB4; AM_ABSX: lk_op = 8'hBC;
        default: lk_legal = 1'b0;
      endcase
      CMD_CPX: case (address)
        AM_IMM: lk_op = 8'hE0;  AM_ZPG: lk_op = 8'hE4;  AM_ABS: lk_op = 8'hEC;
        default: lk_legal = 1'b0;
      endcase
      CMD_CPY: case (address)
        AM_IMM: lk_op = 8'hC0;  AM_ZPG: lk_op = 8'hC4;  AM_ABS: lk_op = 8'hCC;
        default: lk_legal = 1'b0;
      endcase
      CMD_BIT: case (address)
        AM_ZPG: lk_op = 8'h24;  AM_ABS: lk_op = 8'h2C;
        default: lk_legal = 1'b0;
      endcase
      CMD_JMP: case (address)
        AM_ABS: lk_op = 8'h4C;  AM_IND: lk_op = 8'h6C;
        default: lk_legal = 1'b0;
      endcase
      // JSR has a single encoding and always carries an absolute target.
      CMD_JSR: begin lk_op = 8'h20; lk_len = 2'd2; end
      CMD_BPL: begin lk_op = 8'h10; rel_only = 1'b1; end
      CMD_BMI: begin lk_op = 8'h30; rel_only = 1'b1; end
      CMD_BVC: begin lk_op = 8'h50; rel_only = 1'b1; end
      CMD_BVS: begin lk_op = 8'h70; rel_only = 1'b1; end
      CMD_BCC: begin lk_op = 8'h90; rel_only = 1'b1; end
      CMD_BCS: begin lk_op = 8'hB0; rel_only = 1'b1; end
      CMD_BNE: begin lk_op = 8'hD0; rel_only = 1'b1; end
      CMD_BEQ: begin lk_op = 8'hF0; rel_only = 1'b1; end
      CMD_ASLA: begin lk_op = 8'h0A; acc_form = 1'b1; end
      CMD_ROLA: begin lk_op = 8'h2A; acc_form = 1'b1; end
      CMD_LSRA: begin lk_op = 8'h4A; acc_form = 1'b1; end
      CMD_RORA: begin lk_op = 8'h6A; acc_form = 1'b1; end
      CMD_BRK: begin lk_op = 8'h00; imp_only = 1'b1; end
      CMD_PHP: begin lk_op = 8'h08; imp_only = 1'b1; end
      CMD_CLC: begin lk_op = 8'h18; imp_only = 1'b1; end
      CMD_PLP: begin lk_op = 8'h28; imp_only = 1'b1; end
      CMD_SEC: begin lk_op = 8'h38; imp_only = 1'b1; end
      CMD_RTI: begin lk_op = 8'h40; imp_only = 1'b1; end
      CMD_PHA: begin lk_op = 8'h48; imp_only = 1'b1; end
      CMD_CLI: begin lk_op = 8'h58; imp_only = 1'b1; end
      CMD_RTS: begin lk_op = 8'h60; imp_only = 1'b1; end
      CMD_PLA: begin lk_op = 8'h68; imp_only = 1'b1; end
      CMD_SEI: begin lk_op = 8'h78; imp_only = 1'b1; end
      CMD_DEY: begin lk_op = 8'h88; imp_only = 1'b1; end
      CMD_TXA: begin lk_op = 8'h8A; imp_only = 1'b1; end
      CMD_TYA: begin lk_op = 8'h98; imp_only = 1'b1; end
      CMD_TXS: begin lk_op = 8'h9A; imp_only = 1'b1; end
      CMD_TAY: begin lk_op = 8'hA8; imp_only = 1'b1; end
      CMD_TAX: begin lk_op = 8'hAA; imp_only = 1'b1; end
      CMD_CLV: begin lk_op = 8'hB8; imp_only = 1'b1; end
      CMD_TSX: begin lk_op = 8'hBA; imp_only = 1'b1; end
      CMD_INY: begin lk_op = 8'hC8; imp_only = 1'b1; end
      CMD_DEX: begin lk_op = 8'hCA; imp_only = 1'b1; end
      CMD_CLD: begin lk_op = 8'hD8; imp_only = 1'b1; end
      CMD_INX: begin lk_op = 8'hE8; imp_only = 1'b1; end
      CMD_NOP: begin lk_op = 8'hEA; imp_only = 1'b1; end
      CMD_SED: begin lk_op = 8'hF8; imp_only = 1'b1; end
      default: lk_legal = 1'b0;
    endcase
    if (imp_only && address != AM_IMP) lk_legal = 1'b0;
    if (acc_form && address != AM_IMP && address != AM_ACC) lk_legal = 1'b0;
    if (rel_only && address != AM_REL) lk_legal = 1'b0;
  end

  logic       take;
  logic [7:0] acc_op;
  logic [1:0] acc_len;
`ifdef INSTR_ENC_ILLEGAL_NOP_EN
  assign take    = in_valid;
  assign acc_op  = lk_legal ? lk_op : 8'hEA;
  assign acc_len = lk_legal ? lk_len : 2'd0;
`else
  assign take    = in_valid & lk_legal;
  assign acc_op  = lk_op;
  assign acc_len = lk_len;
`endif

  logic [15:0] opnd_reg;
  logic [1:0]  len_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_byte    <= 8'h00;
      out_last    <= 1'b0;
      err         <= 1'b0;
      instr_count <= '0;
      opnd_reg    <= 16'h0000;
      len_reg     <= 2'd0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          err <= in_valid & ~lk_legal;
          if (take) begin
            opnd_reg  <= operand;
            len_reg   <= acc_len;
            out_byte  <= acc_op;
            out_last  <= (acc_len == 2'd0);
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= EMIT_OP;
          end
        end
        EMIT_OP, EMIT_LO, EMIT_HI: begin
          if (out_ready) begin
            if (state == EMIT_OP && len_reg != 2'd0) begin
              out_byte <= opnd_reg[7:0];
              out_last <= (len_reg == 2'd1);
              state    <= EMIT_LO;
            end else if (state == EMIT_LO && len_reg == 2'd2) begin
              out_byte <= opnd_reg[15:8];
              out_last <= 1'b1;
              state    <= EMIT_HI;
            end else begin
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              in_ready    <= 1'b1;
              instr_count <= instr_count + CNT_W'(1);
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// tb_instr_encoder: randomized and directed checks of instr_encoder against a table-driven byte-stream model.
module tb_instr_encoder;

  localparam int BRK=0, ORA=1, ASL=2, PHP=3, BPL=4, CLC=5, JSR=6, AND=7, BIT=8, ROL=9, PLP=10, BMI=11,
    SEC=12, RTI=13, EOR=14, LSR=15, PHA=16, JMP=17, BVC=18, CLI=19, RTS=20, ADC=21, ROR=22, PLA=23,
    BVS=24, SEI=25, STA=26, STY=27, STX=28, DEY=29, TXA=30, BCC=31, TYA=32, TXS=33, LDY=34, LDA=35,
    LDX=36, TAY=37, TAX=38, BCS=39, CLV=40, TSX=41, CPY=42, CMP=43, DEC=44, INY=45, DEX=46, BNE=47,
    CLD=48, CPX=49, SBC=50, INX=51, NOP=52, BEQ=53, SED=54, INC=55, ASLA=56, ROLA=57, LSRA=58, RORA=59;
  localparam int IMP=0, ACC=1, IMM=2, ZPG=3, ZPX=4, ZPY=5, ABS=6, ABX=7, ABY=8, IND=9, IZX=10, IZY=11, REL=12;
`ifdef INSTR_ENC_ILLEGAL_NOP_EN
  localparam int NOPX = 1;
`else
  localparam int NOPX = 0;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, err;
  logic [5:0]  cmd;
  logic [3:0]  address;
  logic [15:0] operand;
  logic [7:0]  out_byte;
  logic [15:0] instr_count;

  instr_encoder #(.CMD_W(6), .ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd), .address(address),
    .operand(operand), .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .err(err), .instr_count(instr_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act !== expv) $display("FAIL %s: got %0h required %0h", name, act, expv);
    else pass_cnt++;
  endtask

  // Decode table (opcode -> mnemonic/mode), inverted into an encode map.
  int         dec_cmd [256];
  int         dec_mode[256];
  bit         dec_ok  [256];
  logic [7:0] enc_op  [1024];
  bit         enc_ok  [1024];

  task automatic d(input int op, input int c, input int m);
    dec_cmd[op] = c; dec_mode[op] = m; dec_ok[op] = 1'b1;
    enc_op[c*16+m] = op[7:0]; enc_ok[c*16+m] = 1'b1;
  endtask

  task automatic build_table();
    for (int i = 0; i < 256; i++) dec_ok[i] = 1'b0;
    for (int i = 0; i < 1024; i++) begin enc_ok[i] = 1'b0; enc_op[i] = 8'h00; end
    d('h00,BRK,IMP); d('h01,ORA,IZX); d('h05,ORA,ZPG); d('h06,ASL,ZPG); d('h08,PHP,IMP); d('h09,ORA,IMM); d('h0A,ASLA,IMP); d('h0D,ORA,ABS); d('h0E,ASL,ABS);
    d('h10,BPL,REL); d('h11,ORA,IZY); d('h15,ORA,ZPX); d('h16,ASL,ZPX); d('h18,CLC,IMP); d('h19,ORA,ABY); d('h1D,ORA,ABX); d('h1E,ASL,ABX);
    d('h20,JSR,ABS); d('h21,AND,IZX); d('h24,BIT,ZPG); d('h25,AND,ZPG); d('h26,ROL,ZPG); d('h28,PLP,IMP); d('h29,AND,IMM); d('h2A,ROLA,IMP); d('h2C,BIT,ABS); d('h2D,AND,ABS); d('h2E,ROL,ABS);
    d('h30,BMI,REL); d('h31,AND,IZY); d('h35,AND,ZPX); d('h36,ROL,ZPX); d('h38,SEC,IMP); d('h39,AND,ABY); d('h3D,AND,ABX); d('h3E,ROL,ABX);
    d('h40,RTI,IMP); d('h41,EOR,IZX); d('h45,EOR,ZPG); d('h46,LSR,ZPG); d('h48,PHA,IMP); d('h49,EOR,IMM); d('h4A,LSRA,IMP); d('h4C,JMP,ABS); d('h4D,EOR,ABS); d('h4E,LSR,ABS);
    d('h50,BVC,REL); d('h51,EOR,IZY); d('h55,EOR,ZPX); d('h56,LSR,ZPX); d('h58,CLI,IMP); d('h59,EOR,ABY); d('h5D,EOR,ABX); d('h5E,LSR,ABX);
    d('h60,RTS,IMP); d('h61,ADC,IZX); d('h65,ADC,ZPG); d('h66,ROR,ZPG); d('h68,PLA,IMP); d('h69,ADC,IMM); d('h6A,RORA,IMP); d('h6C,JMP,IND); d('h6D,ADC,ABS); d('h6E,ROR,ABS);
    d('h70,BVS,REL); d('h71,ADC,IZY); d('h75,ADC,ZPX); d('h76,ROR,ZPX); d('h78,SEI,IMP); d('h79,ADC,ABY); d('h7D,ADC,ABX); d('h7E,ROR,ABX);
    d('h81,STA,IZX); d('h84,STY,ZPG); d('h85,STA,ZPG); d('h86,STX,ZPG); d('h88,DEY,IMP); d('h8A,TXA,IMP); d('h8C,STY,ABS); d('h8D,STA,ABS); d('h8E,STX,ABS);
    d('h90,BCC,REL); d('h91,STA,IZY); d('h94,STY,ZPX); d('h95,STA,ZPX); d('h96,STX,ZPY); d('h98,TYA,IMP); d('h99,STA,ABY); d('h9A,TXS,IMP); d('h9D,STA,ABX);
    d('hA0,LDY,IMM); d('hA1,LDA,IZX); d('hA2,LDX,IMM); d('hA4,LDY,ZPG); d('hA5,LDA,ZPG); d('hA6,LDX,ZPG); d('hA8,TAY,IMP); d('hA9,LDA,IMM); d('hAA,TAX,IMP); d('hAC,LDY,ABS); d('hAD,LDA,ABS); d('hAE,LDX,ABS);
    d('hB0,BCS,REL); d('hB1,LDA,IZY); d('hB4,LDY,ZPX); d('hB5,LDA,ZPX); d('hB6,LDX,ZPY); d('hB8,CLV,IMP); d('hB9,LDA,ABY); d('hBA,TSX,IMP); d('hBC,LDY,ABX); d('hBD,LDA,ABX); d('hBE,LDX,ABY);
    d('hC0,CPY,IMM); d('hC1,CMP,IZX); d('hC4,CPY,ZPG); d('hC5,CMP,ZPG); d('hC6,DEC,ZPG); d('hC8,INY,IMP); d('hC9,CMP,IMM); d('hCA,DEX,IMP); d('hCC,CPY,ABS); d('hCD,CMP,ABS); d('hCE,DEC,ABS);
    d('hD0,BNE,REL); d('hD1,CMP,IZY); d('hD5,CMP,ZPX); d('hD6,DEC,ZPX); d('hD8,CLD,IMP); d('hD9,CMP,ABY); d('hDD,CMP,ABX); d('hDE,DEC,ABX);
    d('hE0,CPX,IMM); d('hE1,SBC,IZX); d('hE4,CPX,ZPG); d('hE5,SBC,ZPG); d('hE6,INC,ZPG); d('hE8,INX,IMP); d('hE9,SBC,IMM); d('hEA,NOP,IMP); d('hEC,CPX,ABS); d('hED,SBC,ABS); d('hEE,INC,ABS);
    d('hF0,BEQ,REL); d('hF1,SBC,IZY); d('hF5,SBC,ZPX); d('hF6,INC,ZPX); d('hF8,SED,IMP); d('hF9,SBC,ABY); d('hFD,SBC,ABX); d('hFE,INC,ABX);
    // Accumulator shifts also accept the explicit A mode; JSR ignores the mode code entirely.
    enc_op[ASLA*16+ACC] = 8'h0A; enc_ok[ASLA*16+ACC] = 1'b1;
    enc_op[ROLA*16+ACC] = 8'h2A; enc_ok[ROLA*16+ACC] = 1'b1;
    enc_op[LSRA*16+ACC] = 8'h4A; enc_ok[LSRA*16+ACC] = 1'b1;
    enc_op[RORA*16+ACC] = 8'h6A; enc_ok[RORA*16+ACC] = 1'b1;
    for (int m = 0; m < 16; m++) begin enc_op[JSR*16+m] = 8'h20; enc_ok[JSR*16+m] = 1'b1; end
  endtask

  function automatic int operand_bytes(input int c, input int m);
    if (c == JSR) return 2;
    if (m == IMM || m == ZPG || m == ZPX || m == ZPY || m == IZX || m == IZY || m == REL) return 1;
    if (m == ABS || m == ABX || m == ABY || m == IND) return 2;
    return 0;
  endfunction

  typedef struct { logic [7:0] b; logic l; int cyc; } byte_t;
  byte_t exp_q[$];
  byte_t seen[$];
  logic  err_exp = 1'b0;
  int    cnt_m = 0;
  int    err_seen = 0;
  int    mcyc = 0;

  // Model: every falling edge, compare against the expected stream, then advance for the coming rising edge.
  always @(negedge clk) begin
    mcyc++;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_err", err, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_out_byte", out_byte, 0);
      chk("rst_out_last", out_last, 0);
      exp_q.delete();
      err_exp = 1'b0;
      cnt_m = 0;
    end else begin
      chk("in_ready", in_ready, exp_q.size() == 0);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("err", err, err_exp);
      chk("instr_count", instr_count, cnt_m[15:0]);
      if (err) err_seen++;
      if (exp_q.size() != 0) begin
        chk("out_byte", out_byte, exp_q[0].b);
        chk("out_last", out_last, exp_q[0].l);
      end
      err_exp = 1'b0;
      if (exp_q.size() != 0) begin
        if (out_ready) begin
          byte_t t;
          t = exp_q.pop_front();
          t.cyc = mcyc;
          seen.push_back(t);
          if (t.l) cnt_m = (cnt_m + 1) % 65536;
        end
      end else if (in_valid) begin
        int key;
        int n;
        key = {cmd, address};
        if (enc_ok[key]) begin
          n = operand_bytes(int'(cmd), int'(address));
          exp_q.push_back('{enc_op[key], n == 0, 0});
          if (n >= 1) exp_q.push_back('{operand[7:0], n == 1, 0});
          if (n == 2) exp_q.push_back('{operand[15:8], 1'b1, 0});
        end else begin
          err_exp = 1'b1;
          if (NOPX == 1) exp_q.push_back('{8'hEA, 1'b1, 0});
        end
      end
    end
  end

  task automatic send(input int c, input int m, input logic [15:0] o);
    int guard;
    guard = 0;
    @(posedge clk); #2;
    cmd = c[5:0]; address = m[3:0]; operand = o; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    cmd = 6'($urandom); address = 4'($urandom); operand = 16'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid) && guard < 300) begin @(negedge clk); guard++; end
    if (guard >= 300) chk("idle_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  task automatic expect_bytes(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] want;
    chk({name, "_len"}, seen.size(), n);
    for (int i = 0; i < n && i < seen.size(); i++) begin
      want = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      chk({name, "_byte"}, seen[i].b, want);
      chk({name, "_last"}, seen[i].l, i == n - 1);
      if (i > 0) chk({name, "_consec"}, seen[i].cyc, seen[i-1].cyc + 1);
    end
    seen.delete();
  endtask

  int e0;
  bit rnd_done;

  initial begin
    build_table();
    rst = 1'b1; in_valid = 1'b0; cmd = '0; address = '0; operand = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_count", instr_count, 0);
    seen.delete();

    send(LDA, IMM, 16'h0042); wait_idle();
    expect_bytes("lda_imm", 2, 8'hA9, 8'h42, 8'h00);
    chk("count_after_lda", instr_count, 1);

    send(JMP, IND, 16'h1234); wait_idle();
    expect_bytes("jmp_ind", 3, 8'h6C, 8'h34, 8'h12);
    send(JSR, IMP, 16'hC000); wait_idle();
    expect_bytes("jsr", 3, 8'h20, 8'h00, 8'hC0);

    e0 = err_seen;
    send(STA, IMM, 16'h0055); wait_idle();
    chk("sta_imm_err_pulses", err_seen - e0, 1);
    if (NOPX == 1) expect_bytes("sta_imm_nop", 1, 8'hEA, 8'h00, 8'h00);
    else expect_bytes("sta_imm_none", 0, 8'h00, 8'h00, 8'h00);
    chk("count_after_sta_imm", instr_count, 3 + NOPX);

    e0 = err_seen;
    send(LDX, ABX, 16'h2001); wait_idle();
    chk("ldx_absx_err_pulses", err_seen - e0, 1);
    if (NOPX == 1) expect_bytes("ldx_absx_nop", 1, 8'hEA, 8'h00, 8'h00);
    else expect_bytes("ldx_absx_none", 0, 8'h00, 8'h00, 8'h00);
    send(LDX, ABY, 16'h2001); wait_idle();
    expect_bytes("ldx_absy", 3, 8'hBE, 8'h01, 8'h20);

    out_ready = 1'b0;
    send(STA, ABX, 16'h0300);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_byte", out_byte, 8'h9D);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    wait_idle();
    expect_bytes("sta_absx", 3, 8'h9D, 8'h00, 8'h03);
    chk("count_after_sta_absx", instr_count, 5 + 2 * NOPX);

    out_ready = 1'b0;
    send(LDA, ABS, 16'h5678);
    @(negedge clk); chk("lda_abs_op", out_byte, 8'hAD);
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    @(negedge clk); chk("lda_abs_lo", out_byte, 8'h78); chk("lda_abs_lo_last", out_last, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("rst_drops_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("count_after_rst", instr_count, 0);
    chk("ready_after_rst", in_ready, 1);
    out_ready = 1'b1;
    seen.delete();
    send(NOP, IMP, 16'hFFFF); wait_idle();
    expect_bytes("nop_after_rst", 1, 8'hEA, 8'h00, 8'h00);
    seen.delete();

    rnd_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 250; t++) begin
          int c, m, op;
          if ($urandom_range(0, 1) == 1) begin
            do op = $urandom_range(0, 255); while (!dec_ok[op]);
            c = dec_cmd[op]; m = dec_mode[op];
          end else begin
            c = $urandom_range(0, 63); m = $urandom_range(0, 15);
          end
          send(c, m, 16'($urandom));
          if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
